// File: rtl/audioport_ctrl_fsm.sv
// audioport_ctrl_fsm: command sequencer, STANDBY/PLAY FSM, sample-rate divider.
// Optional tick counter output enabled by defining AUDIOPORT_TICK_COUNT_EN.
module audioport_ctrl_fsm #(
    parameter int BUF_AW    = 4,
    parameter int RATE_DIV0 = 2268,
    parameter int RATE_DIV1 = 1134,
    parameter int RATE_DIV2 = 567,
    parameter int RATE_DIV3 = 283
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_in,
    input  logic [31:0]       cmd_in,
    input  logic [31:0]       cfg_reg_in,
    input  logic [BUF_AW:0]   buf_level_in,
    output logic              play_out,
    output logic              tick_out,
    output logic              clr_out,
    output logic              cfg_out,
    output logic              level_out,
    output logic              irq_out,
    output logic              cmd_err_out,
    output logic [31:0]       status_out
`ifdef AUDIOPORT_TICK_COUNT_EN
    ,
    output logic [31:0]       tick_count_out
`endif
);

    typedef enum logic {
        STANDBY = 1'b0,
        PLAY    = 1'b1
    } state_t;

`ifdef AUDIOPORT_TICK_COUNT_EN
    localparam logic FEAT = 1'b1;
`else
    localparam logic FEAT = 1'b0;
`endif

    state_t      state;
    logic [1:0]  rate;
    logic [31:0] cnt;
    logic [31:0] div_last;

    logic do_clr;
    logic do_cfg;
    logic do_start;
    logic do_stop;
    logic do_level;
    logic do_ack;
    logic do_err;

    // Only the rate select field of the config register matters here.
    logic cfg_unused;
    assign cfg_unused = ^cfg_reg_in[31:2];

    // Decode the incoming command against the current state.
    always_comb begin
        do_clr   = 1'b0;
        do_cfg   = 1'b0;
        do_start = 1'b0;
        do_stop  = 1'b0;
        do_level = 1'b0;
        do_ack   = 1'b0;
        do_err   = 1'b0;
        if (cmd_valid_in) begin
            if (|cmd_in[31:3]) begin
                do_err = 1'b1;
            end else begin
                unique case (cmd_in[2:0])
                    3'd0: ;
                    3'd1: begin
                        if (state == PLAY) do_err = 1'b1;
                        else               do_clr = 1'b1;
                    end
                    3'd2: begin
                        if (state == PLAY) do_err = 1'b1;
                        else               do_cfg = 1'b1;
                    end
                    3'd3: do_start = 1'b1;
                    3'd4: do_stop  = 1'b1;
                    3'd5: do_level = 1'b1;
                    3'd6: do_ack   = 1'b1;
                    default: do_err = 1'b1;
                endcase
            end
        end
    end

    // Terminal count of the divider for the latched rate.
    always_comb begin
        div_last = 32'(RATE_DIV0 - 1);
        unique case (rate)
            2'd0: div_last = 32'(RATE_DIV0 - 1);
            2'd1: div_last = 32'(RATE_DIV1 - 1);
            2'd2: div_last = 32'(RATE_DIV2 - 1);
            2'd3: div_last = 32'(RATE_DIV3 - 1);
            default: div_last = 32'(RATE_DIV0 - 1);
        endcase
    end

    // State machine, divider, interrupt and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= STANDBY;
            rate        <= 2'd0;
            cnt         <= 32'd0;
            play_out    <= 1'b0;
            tick_out    <= 1'b0;
            clr_out     <= 1'b0;
            cfg_out     <= 1'b0;
            level_out   <= 1'b0;
            irq_out     <= 1'b0;
            cmd_err_out <= 1'b0;
            status_out  <= 32'd0;
        end else begin
            clr_out     <= do_clr;
            cfg_out     <= do_cfg;
            level_out   <= do_level;
            cmd_err_out <= do_err;
            tick_out    <= 1'b0;
            if (do_cfg) rate <= cfg_reg_in[1:0];

            unique case (state)
                STANDBY: begin
                    if (do_start) begin
                        state    <= PLAY;
                        play_out <= 1'b1;
                        cnt      <= 32'd0;
                    end
                end
                PLAY: begin
                    if (do_stop) begin
                        state    <= STANDBY;
                        play_out <= 1'b0;
                        cnt      <= 32'd0;
                    end else if (cnt == div_last) begin
                        cnt      <= 32'd0;
                        tick_out <= 1'b1;
                    end else begin
                        cnt      <= cnt + 32'd1;
                    end
                end
                default: state <= STANDBY;
            endcase

            // A new underrun beats a simultaneous acknowledge.
            if (state == PLAY && do_stop)
                irq_out <= 1'b0;
            else if (tick_out && buf_level_in == '0)
                irq_out <= 1'b1;
            else if (do_ack)
                irq_out <= 1'b0;

            status_out <= {27'd0, FEAT, rate, irq_out, play_out};
        end
    end

`ifdef AUDIOPORT_TICK_COUNT_EN
    // Free-running count of emitted sample ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_count_out <= 32'd0;
        else if (do_clr)
            tick_count_out <= 32'd0;
        else if (tick_out)
            tick_count_out <= tick_count_out + 32'd1;
    end
`endif

endmodule

// File: tb/tb_audioport_ctrl_fsm.sv
// tb_audioport_ctrl_fsm: scoreboard bench for audioport_ctrl_fsm.
// Strobes and ticks are queued at issue and popped when the DUT shows them.
module tb_audioport_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_in;
    logic [31:0] cmd_in;
    logic [31:0] cfg_reg_in;
    logic [4:0]  buf_level_in;
    logic        play_out;
    logic        tick_out;
    logic        clr_out;
    logic        cfg_out;
    logic        level_out;
    logic        irq_out;
    logic        cmd_err_out;
    logic [31:0] status_out;
`ifdef AUDIOPORT_TICK_COUNT_EN
    logic [31:0] tick_count_out;
    localparam logic [31:0] FEAT = 32'h10;
`else
    localparam logic [31:0] FEAT = 32'h0;
`endif

    audioport_ctrl_fsm #(
        .BUF_AW(4),
        .RATE_DIV0(8),
        .RATE_DIV1(6),
        .RATE_DIV2(4),
        .RATE_DIV3(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid_in(cmd_valid_in),
        .cmd_in(cmd_in),
        .cfg_reg_in(cfg_reg_in),
        .buf_level_in(buf_level_in),
        .play_out(play_out),
        .tick_out(tick_out),
        .clr_out(clr_out),
        .cfg_out(cfg_out),
        .level_out(level_out),
        .irq_out(irq_out),
        .cmd_err_out(cmd_err_out),
        .status_out(status_out)
`ifdef AUDIOPORT_TICK_COUNT_EN
        ,
        .tick_count_out(tick_count_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] v;
    } sp_t;

    sp_t sq[$];
    int  tq[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pop an expectation whenever the DUT shows a tick or strobe.
    always @(negedge clk) begin : mon
        int   e;
        sp_t  p;
        if (!rst) begin
            if (tick_out) begin
                if (tq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tick_spurious: got tick at %0d expected none",
                             cyc);
                end else begin
                    e = tq.pop_front();
                    chk("tick_cycle", cyc, e);
                end
            end
            if (clr_out | cfg_out | level_out | cmd_err_out) begin
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_spurious: got %b at %0d expected none",
                             {clr_out, cfg_out, level_out, cmd_err_out}, cyc);
                end else begin
                    p = sq.pop_front();
                    chk("strobe_cycle", cyc, p.cyc);
                    chk("strobe_vec",
                        {27'd0, clr_out, cfg_out, level_out, cmd_err_out, play_out},
                        {27'd0, p.v});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    // v = {clr, cfg, level, err, play} expected one cycle after issue
    task automatic cmd(input logic [31:0] c, input bit has,
                       input logic [4:0] v);
        cmd_valid_in = 1'b1;
        cmd_in       = c;
        step();
        cmd_valid_in = 1'b0;
        cmd_in       = 32'd0;
        if (has) sq.push_back('{cyc, v});
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, play_out, tick_out, clr_out, cfg_out,
                level_out, irq_out, cmd_err_out};
    endfunction

    int s;
    int r;

    initial begin
        rst          = 1'b1;
        cmd_valid_in = 1'b0;
        cmd_in       = 32'd0;
        cfg_reg_in   = 32'd0;
        buf_level_in = 5'd4;
        step();
        step();
        chk("reset_outs", outs(), 32'd0);
        chk("reset_status", status_out, 32'd0);
        rst = 1'b0;
        step();

        // STANDBY command handling
        cfg_reg_in = 32'h3;
        cmd(32'd2, 1'b1, 5'b01000);
        cfg_reg_in = 32'h0;
        step();
        chk("status_rate3", status_out, 32'h0000000C | FEAT);
        cmd(32'd1, 1'b1, 5'b10000);
        cmd(32'd5, 1'b1, 5'b00100);
        cmd(32'd7, 1'b1, 5'b00010);
        cmd(32'h9, 1'b1, 5'b00010);
        cmd(32'd4, 1'b0, 5'b00000);
        cmd(32'd0, 1'b0, 5'b00000);

        // PLAY at rate 0 (period 8)
        cmd(32'd2, 1'b1, 5'b01000);
        cmd(32'd3, 1'b0, 5'b00000);
        s = cyc;
        chk("play_on", {31'd0, play_out}, 32'd1);
        for (int k = 1; k <= 6; k++) tq.push_back(s + 8 * k);

        wait_until(s + 25);
        chk("irq_quiet", {31'd0, irq_out}, 32'd0);
        buf_level_in = 5'd0;
        wait_until(s + 33);
        chk("irq_set", {31'd0, irq_out}, 32'd1);
        step();
        chk("status_play_irq", status_out, 32'h3 | FEAT);
        wait_until(s + 35);
        chk("irq_sticky", {31'd0, irq_out}, 32'd1);
        buf_level_in = 5'd4;
        cmd(32'd6, 1'b0, 5'b00000);
        chk("irq_ack", {31'd0, irq_out}, 32'd0);
        buf_level_in = 5'd0;
        wait_until(s + 40);
        cmd(32'd6, 1'b0, 5'b00000);
        chk("irq_ack_vs_set", {31'd0, irq_out}, 32'd1);
        buf_level_in = 5'd4;

        // rejected commands in PLAY
        cfg_reg_in = 32'h3;
        cmd(32'd1, 1'b1, 5'b00011);
        cmd(32'd2, 1'b1, 5'b00011);
        cmd(32'h13, 1'b1, 5'b00011);
        cmd(32'd5, 1'b1, 5'b00101);
        cfg_reg_in = 32'h0;
        chk("play_kept", {31'd0, play_out}, 32'd1);

        // STOP one cycle before the next tick
        wait_until(s + 55);
        chk("irq_before_stop", {31'd0, irq_out}, 32'd1);
        cmd(32'd4, 1'b0, 5'b00000);
        chk("stop_outs", outs(), 32'd0);
        step();
        chk("status_stopped", status_out, FEAT);

        // reset in the middle of PLAY at rate 3 (period 2)
        cfg_reg_in = 32'h3;
        cmd(32'd2, 1'b1, 5'b01000);
        cfg_reg_in   = 32'h0;
        buf_level_in = 5'd0;
        cmd(32'd3, 1'b0, 5'b00000);
        r = cyc;
        tq.push_back(r + 2);
        wait_until(r + 3);
        chk("irq_fast", {31'd0, irq_out, 1'b0} | {31'd0, play_out}, 32'd3);
        rst = 1'b1;
        #1;
        chk("async_rst_outs", outs(), 32'd0);
        chk("async_rst_status", status_out, 32'd0);
        step();
        step();
        rst = 1'b0;
        buf_level_in = 5'd4;
        repeat (4) step();
        chk("post_rst_outs", outs(), 32'd0);
        chk("post_rst_status", status_out, FEAT);
`ifdef AUDIOPORT_TICK_COUNT_EN
        chk("post_rst_tick_count", tick_count_out, 32'd0);
`endif
        cmd(32'd5, 1'b1, 5'b00100);
        repeat (3) step();

        chk("tick_q_empty", tq.size(), 32'd0);
        chk("strobe_q_empty", sq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
